// File: rtl/cache_arb_types.sv
// Shared types for the cache arbiter: FSM state encoding and default widths.
package cache_arb_types;
  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_I  = 2'd1,
    SERVE_D  = 2'd2,
    COOLDOWN = 2'd3
  } arb_state_e;
endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one cacheline adaptor.
// Optional macro CACHE_ARB_RR_EN: round-robin tie-break instead of fixed dcache priority.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              cla_read,
  output logic              cla_write,
  output logic [ADDR_W-1:0] cla_address,
  output logic [LINE_W-1:0] cla_wdata,
  input  logic [LINE_W-1:0] cla_rdata,
  input  logic              cla_resp
);
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              d_req, i_req, pick_d;

  assign d_req = dcache_pmem_read | dcache_pmem_write;
  assign i_req = icache_pmem_read;

`ifdef CACHE_ARB_RR_EN
  // 1 = dcache granted last; reset value lets dcache win the first tie.
  logic last_d_q, last_d_d;
  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    write_d          = write_q;
    cla_read         = 1'b0;
    cla_write        = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
`ifdef CACHE_ARB_RR_EN
    last_d_d         = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
          addr_d  = dcache_pmem_address;
          wdata_d = dcache_pmem_wdata;
          write_d = dcache_pmem_write;  // read+write together is a writeback
`ifdef CACHE_ARB_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d = SERVE_I;
          addr_d  = icache_pmem_address;
          wdata_d = '0;
          write_d = 1'b0;
`ifdef CACHE_ARB_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        cla_read  = ~write_q;
        cla_write = write_q;
        if (cla_resp) begin
          state_d = COOLDOWN;
          if (state_q == SERVE_I) icache_pmem_resp = 1'b1;
          else                    dcache_pmem_resp = 1'b1;
        end
      end
      // One dead cycle so a requester dropping on resp is not re-granted.
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign cla_address       = addr_q;
  assign cla_wdata         = wdata_q;
  assign icache_pmem_rdata = cla_rdata;
  assign dcache_pmem_rdata = cla_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; honours CACHE_ARB_RR_EN if defined.
module tb_cache_arbiter;
  import cache_arb_types::*;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read, dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata, dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          cla_read, cla_write;
  logic [AW-1:0] cla_address;
  logic [LW-1:0] cla_wdata, cla_rdata;
  logic          cla_resp;

  int checks = 0;
  int fails  = 0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .cla_read(cla_read), .cla_write(cla_write), .cla_address(cla_address),
    .cla_wdata(cla_wdata), .cla_rdata(cla_rdata), .cla_resp(cla_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (cla_read && cla_write) begin
      fails++;
      $display("FAIL excl_strobes: read=%b write=%b, required not both 1", cla_read, cla_write);
    end
  end

  task automatic test_reset();
    rst = 1'b0; cla_resp = 1'b0; cla_rdata = '0;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if ({cla_read, cla_write} !== 2'b00) begin fails++;
      $display("FAIL rst_strobes: got %b%b required 00", cla_read, cla_write); end
    checks++; if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin fails++;
      $display("FAIL rst_resp: got %b%b required 00", icache_pmem_resp, dcache_pmem_resp); end
    checks++; if (dut.state_q !== IDLE) begin fails++;
      $display("FAIL rst_state: got %0d required %0d", dut.state_q, IDLE); end
    checks++; if (cla_address !== '0 || cla_wdata !== '0 || dut.write_q !== 1'b0) begin fails++;
      $display("FAIL rst_latch: addr %h dir %b, required 0", cla_address, dut.write_q); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_icache_read();
    logic [LW-1:0] pat;
    pat = {32{8'hA5}};
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0040;
    @(negedge clk);
    checks++; if ({cla_read, cla_write} !== 2'b10 || cla_address !== 32'h40) begin fails++;
      $display("FAIL i_grant: rd=%b wr=%b addr=%h required 1 0 00000040", cla_read, cla_write, cla_address); end
    icache_pmem_read = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cla_read !== 1'b1 || dut.state_q !== SERVE_I) begin fails++;
      $display("FAIL i_hold: rd=%b state=%0d required 1 %0d", cla_read, dut.state_q, SERVE_I); end
    cla_rdata = pat; cla_resp = 1'b1;
    #1;
    checks++; if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b10) begin fails++;
      $display("FAIL i_resp: i=%b d=%b required 1 0", icache_pmem_resp, dcache_pmem_resp); end
    checks++; if (icache_pmem_rdata !== pat) begin fails++;
      $display("FAIL i_rdata: got %h required %h", icache_pmem_rdata, pat); end
    @(negedge clk);
    cla_resp = 1'b0;
    checks++; if (dut.state_q !== COOLDOWN || {cla_read, cla_write} !== 2'b00) begin fails++;
      $display("FAIL i_cool: state=%0d strobes=%b%b required %0d 00", dut.state_q, cla_read, cla_write, COOLDOWN); end
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin fails++;
      $display("FAIL i_idle: state=%0d required %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_priority();
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h100;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h200; dcache_pmem_wdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    checks++; if ({cla_read, cla_write} !== 2'b01 || cla_address !== 32'h200) begin fails++;
      $display("FAIL pri_d_first: rd=%b wr=%b addr=%h required 0 1 00000200", cla_read, cla_write, cla_address); end
    checks++; if (cla_wdata !== {8{32'hDEAD_BEEF}}) begin fails++;
      $display("FAIL pri_wdata: got %h", cla_wdata); end
    cla_resp = 1'b1;
    #1;
    checks++; if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b01) begin fails++;
      $display("FAIL pri_d_resp: i=%b d=%b required 0 1", icache_pmem_resp, dcache_pmem_resp); end
    dcache_pmem_write = 1'b0;
    @(negedge clk);
    cla_resp = 1'b0;
    checks++; if ({cla_read, cla_write} !== 2'b00) begin fails++;
      $display("FAIL pri_cool: strobes=%b%b required 00", cla_read, cla_write); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({cla_read, cla_write} !== 2'b10 || cla_address !== 32'h100) begin fails++;
      $display("FAIL pri_i_second: rd=%b wr=%b addr=%h required 1 0 00000100", cla_read, cla_write, cla_address); end
    icache_pmem_read = 1'b0;
    cla_resp = 1'b1;
    @(negedge clk);
    cla_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_stable();
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h200; dcache_pmem_wdata = {LW{1'b1}};
    @(negedge clk);
    dcache_pmem_address = 32'h300; dcache_pmem_wdata = '0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (cla_address !== 32'h200 || cla_wdata !== {LW{1'b1}} || cla_write !== 1'b1) begin fails++;
        $display("FAIL addr_stable: addr=%h wr=%b required 00000200 1", cla_address, cla_write); end
    end
    dcache_pmem_write = 1'b0;
    cla_resp = 1'b1;
    @(negedge clk);
    cla_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rw_both();
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h80;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({cla_read, cla_write} !== 2'b01 || cla_address !== 32'h80) begin fails++;
        $display("FAIL rw_both: cyc %0d rd=%b wr=%b addr=%h required 0 1 00000080", c, cla_read, cla_write, cla_address); end
    end
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    cla_resp = 1'b1;
    @(negedge clk);
    cla_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic got_d, exp_d;
    int   wait_cyc;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h100;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      wait_cyc = 0;
      do begin
        @(negedge clk);
        wait_cyc++;
      end while (!(cla_read || cla_write) && wait_cyc < 8);
`ifdef CACHE_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      got_d = cla_write && (cla_address == 32'h200);
      checks++; if (!(cla_read || cla_write) || got_d !== exp_d) begin fails++;
        $display("FAIL b2b_grant%0d: got_d=%b required %b (waited %0d)", k, got_d, exp_d, wait_cyc); end
      cla_resp = 1'b1;
      @(negedge clk);
      cla_resp = 1'b0;
    end
    icache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    dcache_pmem_read = 1'b1; dcache_pmem_address = 32'h440;
    @(negedge clk);
    checks++; if (dut.state_q !== SERVE_D || cla_read !== 1'b1) begin fails++;
      $display("FAIL rm_serve: state=%0d rd=%b required %0d 1", dut.state_q, cla_read, SERVE_D); end
    rst = 1'b0; dcache_pmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin fails++;
      $display("FAIL rm_state: state=%0d required %0d", dut.state_q, IDLE); end
    checks++; if ({cla_read, cla_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000) begin fails++;
      $display("FAIL rm_outs: rd wr iresp dresp=%b%b%b%b required 0000",
               cla_read, cla_write, icache_pmem_resp, dcache_pmem_resp); end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_priority();
    test_addr_stable();
    test_rw_both();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
